// File: rtl/sprite_bus_writer.sv
// -----------------------------------------------------------------------------
// sprite_bus_writer
//   Initiator side of the sprite-position write bus into the graphics RAM.
//   Position updates arrive over a valid/ready handshake, are clamped to the
//   visible area, queued in a small FIFO and serialised one at a time into a
//   wrn low pulse. The RAM commits sprite_id/x/y on the 0->1 edge of wrn.
//   Each write goes IDLE -> SETUP -> LOW -> HOLD -> IDLE.
//
//   Handshake: a request transfers on a rising clk edge where
//   req_valid && req_ready. req_ready is registered and depends only on the
//   FIFO level, never on req_valid. A request presented while req_ready is low
//   is dropped and sets the sticky overflow flag.
//
//   Optional feature macro: VBLANK_SYNC_EN. When defined, a new write is only
//   started while vblank=1. A write that has already left IDLE always runs to
//   completion. When undefined, vblank is ignored.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   req_valid     update request present
//   req_ready     FIFO can accept (registered, level != FIFO_DEPTH)
//   req_id/x/y    update payload (x/y clamped to X_MAX/Y_MAX on enqueue)
//   vblank        vertical blank (used only with VBLANK_SYNC_EN)
//   sprite_id/x/y write-bus data, changes only on IDLE->SETUP
//   wrn           write strobe, idle high
//   busy          FSM not idle or FIFO non-empty
//   level         FIFO occupancy
//   overflow      sticky: valid seen while not ready
//   fsm_state     debug view of the FSM state
// -----------------------------------------------------------------------------
module sprite_bus_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int LOW_CYC    = 2,
    parameter int HOLD_CYC   = 1,
    parameter int X_MAX      = 639,
    parameter int Y_MAX      = 479
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [7:0]                      req_id,
    input  logic [9:0]                      req_x,
    input  logic [8:0]                      req_y,
    input  logic                            vblank,
    output logic [7:0]                      sprite_id,
    output logic [9:0]                      sprite_x,
    output logic [8:0]                      sprite_y,
    output logic                            wrn,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     level,
    output logic                            overflow,
    output logic [1:0]                      fsm_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CMAX = (LOW_CYC > HOLD_CYC) ? LOW_CYC : HOLD_CYC;
    localparam int CW = (CMAX < 2) ? 1 : $clog2(CMAX);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_LOW   = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          wrn_nxt;

    logic [26:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_nxt;

    logic          gate_open;
    logic          push, pop;
    logic [9:0]    clamp_x;
    logic [8:0]    clamp_y;

`ifdef VBLANK_SYNC_EN
    assign gate_open = vblank;
`else
    assign gate_open = 1'b1;
`endif

    assign fsm_state = state;
    assign push      = req_valid && req_ready;
    assign pop       = (state == S_IDLE) && (level != '0) && gate_open;
    assign clamp_x   = (req_x > 10'(X_MAX)) ? 10'(X_MAX) : req_x;
    assign clamp_y   = (req_y > 9'(Y_MAX))  ? 9'(Y_MAX)  : req_y;
    assign level_nxt = level + LW'(push) - LW'(pop);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wrn_nxt   = wrn;
        case (state)
            S_IDLE: begin
                if (pop) state_nxt = S_SETUP;
            end
            S_SETUP: begin
                state_nxt = S_LOW;
                wrn_nxt   = 1'b0;
                cnt_nxt   = CW'(LOW_CYC - 1);
            end
            S_LOW: begin
                if (cnt == '0) begin
                    // Rising edge of wrn is the commit point for the RAM.
                    state_nxt = S_HOLD;
                    wrn_nxt   = 1'b1;
                    cnt_nxt   = CW'(HOLD_CYC - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                if (cnt == '0) state_nxt = S_IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
        endcase
    end

    // Storage carries no reset; occupancy is tracked by the pointers/level.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {req_id, clamp_x, clamp_y};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            wrn       <= 1'b1;
            sprite_id <= 8'hFF;
            sprite_x  <= '0;
            sprite_y  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            wrn   <= wrn_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                {sprite_id, sprite_x, sprite_y} <= mem[rd_ptr];
            end
            level     <= level_nxt;
            req_ready <= (level_nxt != LW'(FIFO_DEPTH));
            busy      <= (state_nxt != S_IDLE) || (level_nxt != '0);
            if (req_valid && !req_ready) overflow <= 1'b1;
        end
    end

endmodule
